// File: rtl/clockmon_rstgen_pkg.sv
// Shared types for the clock-monitor driven staged reset generator.
package clockmon_rstgen_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    QUALIFY = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/clockmon_rstgen.sv
// Qualifies the clock-present flag and sequences staged active-high resets
// for the monitored clock domain; tracks loss events for status.
module clockmon_rstgen #(
  parameter int unsigned STABLE  = 16,
  parameter int unsigned NRST    = 2,
  parameter int unsigned GAP     = 4,
  parameter int unsigned LCWIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               detected,
  input  logic               clear,
  output logic [NRST-1:0]    rst_out,
  output logic               ready,
  output logic               lost,
  output logic [LCWIDTH-1:0] loss_cnt
);
  import clockmon_rstgen_pkg::*;

  localparam int unsigned QW = $clog2(STABLE + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam int unsigned IW = $clog2(NRST + 1);

  state_t             state, state_nxt;
  logic [QW-1:0]      qcnt, qcnt_nxt;
  logic [GW-1:0]      gcnt, gcnt_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [NRST-1:0]    rst_out_nxt;
  logic               ready_nxt;
  logic               lost_nxt;
  logic [LCWIDTH-1:0] loss_cnt_nxt;
  logic               drop;
  logic               loss_ev;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HOLD;
      qcnt     <= '0;
      gcnt     <= '0;
      idx      <= '0;
      rst_out  <= '1;
      ready    <= 1'b0;
      lost     <= 1'b0;
      loss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      qcnt     <= qcnt_nxt;
      gcnt     <= gcnt_nxt;
      idx      <= idx_nxt;
      rst_out  <= rst_out_nxt;
      ready    <= ready_nxt;
      lost     <= lost_nxt;
      loss_cnt <= loss_cnt_nxt;
    end
  end

  // Next-state, staged release sequencing and loss bookkeeping
  always_comb begin
    state_nxt    = state;
    qcnt_nxt     = qcnt;
    gcnt_nxt     = gcnt;
    idx_nxt      = idx;
    rst_out_nxt  = rst_out;
    ready_nxt    = ready;
    lost_nxt     = lost;
    loss_cnt_nxt = loss_cnt;

    drop    = !detected && (state != HOLD);
    loss_ev = drop && (state == RUN);

    case (state)
      HOLD: begin
        if (detected) begin
          state_nxt = QUALIFY;
          qcnt_nxt  = '0;
        end
      end
      QUALIFY: begin
        if (qcnt == QW'(STABLE - 1)) begin
          state_nxt   = RELEASE;
          rst_out_nxt = NRST'(rst_out << 1);
          idx_nxt     = IW'(1);
          gcnt_nxt    = '0;
        end else begin
          qcnt_nxt = qcnt + QW'(1);
        end
      end
      RELEASE: begin
        // Bits release low-first by shifting a zero in from the bottom
        if (idx == IW'(NRST)) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end else if (gcnt == GW'(GAP - 1)) begin
          rst_out_nxt = NRST'(rst_out << 1);
          idx_nxt     = idx + IW'(1);
          gcnt_nxt    = '0;
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      RUN: begin
        ready_nxt = 1'b1;
      end
      default: state_nxt = HOLD;
    endcase

    // Losing the clock overrides any progress; no partial credit is kept
    if (drop) begin
      state_nxt   = HOLD;
      qcnt_nxt    = '0;
      gcnt_nxt    = '0;
      idx_nxt     = '0;
      rst_out_nxt = '1;
      ready_nxt   = 1'b0;
    end

    if (clear) begin
      lost_nxt     = 1'b0;
      loss_cnt_nxt = '0;
    end

    // A loss on the same edge as clear survives the clear
    if (loss_ev) begin
      lost_nxt = 1'b1;
      if (loss_cnt_nxt != '1) begin
        loss_cnt_nxt = loss_cnt_nxt + LCWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_clockmon_rstgen.sv
// Directed bench for clockmon_rstgen: default, narrow-counter and minimal instances.
module tb_clockmon_rstgen;

  logic clk = 1'b0;
  logic reset;
  logic detected;
  logic clear;

  logic [1:0] rst_d;
  logic       ready_d, lost_d;
  logic [7:0] cnt_d;

  logic [1:0] rst_l;
  logic       ready_l, lost_l;
  logic [1:0] cnt_l;

  logic [0:0] rst_m;
  logic       ready_m, lost_m;
  logic [7:0] cnt_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clockmon_rstgen dut (
    .clk(clk), .reset(reset), .detected(detected), .clear(clear),
    .rst_out(rst_d), .ready(ready_d), .lost(lost_d), .loss_cnt(cnt_d)
  );

  clockmon_rstgen #(.LCWIDTH(2)) dut_lc (
    .clk(clk), .reset(reset), .detected(detected), .clear(clear),
    .rst_out(rst_l), .ready(ready_l), .lost(lost_l), .loss_cnt(cnt_l)
  );

  clockmon_rstgen #(.STABLE(1), .NRST(1), .GAP(1)) dut_min (
    .clk(clk), .reset(reset), .detected(detected), .clear(clear),
    .rst_out(rst_m), .ready(ready_m), .lost(lost_m), .loss_cnt(cnt_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; detected = 1'b0; clear = 1'b0;
    #2;
    checks++;
    if ({rst_d, ready_d, lost_d, cnt_d} !== {2'b11, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_async_init: got rst=%b rdy=%b lost=%b cnt=%0d want 11 0 0 0",
               rst_d, ready_d, lost_d, cnt_d);
    end
    repeat (3) tick();
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      checks++;
      if ({rst_d, ready_d, lost_d, cnt_d} !== {2'b11, 1'b0, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: got rst=%b rdy=%b lost=%b cnt=%0d want 11 0 0 0",
                 k, rst_d, ready_d, lost_d, cnt_d);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] exp_r;
    for (int k = 0; k <= 28; k++) begin
      detected = (k != 10);
      tick();
      exp_r = (k < 27) ? 2'b11 : 2'b10;
      checks++;
      if ({rst_d, ready_d} !== {exp_r, 1'b0}) begin
        errors++;
        $display("FAIL glitch_requal k=%0d: got rst=%b rdy=%b want %b 0", k, rst_d, ready_d, exp_r);
      end
    end
    detected = 1'b0;
    tick();
    checks++;
    if ({rst_d, ready_d, lost_d, cnt_d} !== {2'b11, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL glitch_no_loss: got rst=%b rdy=%b lost=%b cnt=%0d want 11 0 0 0",
               rst_d, ready_d, lost_d, cnt_d);
    end
  endtask

  task automatic test_release();
    logic [1:0] exp_r;
    detected = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      tick();
      exp_r = (k < 16) ? 2'b11 : (k < 20) ? 2'b10 : 2'b00;
      checks++;
      if ({rst_d, ready_d} !== {exp_r, (k >= 21)}) begin
        errors++;
        $display("FAIL release_seq k=%0d: got rst=%b rdy=%b want %b %b",
                 k, rst_d, ready_d, exp_r, (k >= 21));
      end
      checks++;
      if ({rst_m, ready_m} !== {(k < 1), (k >= 2)}) begin
        errors++;
        $display("FAIL release_min k=%0d: got rst=%b rdy=%b want %b %b",
                 k, rst_m, ready_m, (k < 1), (k >= 2));
      end
    end
    checks++;
    if ({lost_d, cnt_d} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL release_no_loss: got lost=%b cnt=%0d want 0 0", lost_d, cnt_d);
    end
  endtask

  task automatic test_run_drops();
    logic [1:0] exp_r;
    for (int d = 0; d < 3; d++) begin
      detected = 1'b0;
      tick();
      checks++;
      if ({rst_d, ready_d, lost_d, cnt_d} !== {2'b11, 1'b0, 1'b1, 8'(d + 1)}) begin
        errors++;
        $display("FAIL run_drop d=%0d: got rst=%b rdy=%b lost=%b cnt=%0d want 11 0 1 %0d",
                 d, rst_d, ready_d, lost_d, cnt_d, d + 1);
      end
      detected = 1'b1;
      for (int k = 0; k <= 21; k++) begin
        tick();
        exp_r = (k < 16) ? 2'b11 : (k < 20) ? 2'b10 : 2'b00;
        checks++;
        if ({rst_d, ready_d} !== {exp_r, (k >= 21)}) begin
          errors++;
          $display("FAIL run_requal d=%0d k=%0d: got rst=%b rdy=%b want %b %b",
                   d, k, rst_d, ready_d, exp_r, (k >= 21));
        end
      end
    end
    checks++;
    if ({lost_d, cnt_d, lost_l, cnt_l} !== {1'b1, 8'd3, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL run_drop_count: got lost=%b cnt=%0d lc_lost=%b lc_cnt=%0d want 1 3 1 3",
               lost_d, cnt_d, lost_l, cnt_l);
    end
  endtask

  task automatic test_saturate();
    for (int d = 0; d < 2; d++) begin
      detected = 1'b1;
      repeat (22) tick();
      checks++;
      if (ready_l !== 1'b1) begin
        errors++;
        $display("FAIL sat_runup d=%0d: got rdy=%b want 1", d, ready_l);
      end
      detected = 1'b0;
      tick();
      checks++;
      if ({cnt_l, cnt_d} !== {2'd3, 8'(4 + d)}) begin
        errors++;
        $display("FAIL sat_count d=%0d: got lc_cnt=%0d cnt=%0d want 3 %0d", d, cnt_l, cnt_d, 4 + d);
      end
    end
    detected = 1'b1;
    repeat (22) tick();
    detected = 1'b0;
    clear = 1'b1;
    tick();
    checks++;
    if ({lost_l, cnt_l, lost_d, cnt_d, rst_d} !== {1'b1, 2'd1, 1'b1, 8'd1, 2'b11}) begin
      errors++;
      $display("FAIL clear_vs_loss: got lc_lost=%b lc_cnt=%0d lost=%b cnt=%0d rst=%b want 1 1 1 1 11",
               lost_l, cnt_l, lost_d, cnt_d, rst_d);
    end
    tick();
    clear = 1'b0;
    checks++;
    if ({lost_l, cnt_l, lost_d, cnt_d, rst_d} !== {1'b0, 2'd0, 1'b0, 8'd0, 2'b11}) begin
      errors++;
      $display("FAIL clear_alone: got lc_lost=%b lc_cnt=%0d lost=%b cnt=%0d rst=%b want 0 0 0 0 11",
               lost_l, cnt_l, lost_d, cnt_d, rst_d);
    end
  endtask

  task automatic test_async_reset();
    detected = 1'b1;
    repeat (22) tick();
    detected = 1'b0;
    tick();
    detected = 1'b1;
    repeat (18) tick();
    checks++;
    if ({rst_d, ready_d, lost_d, cnt_d} !== {2'b10, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL async_setup: got rst=%b rdy=%b lost=%b cnt=%0d want 10 0 1 1",
               rst_d, ready_d, lost_d, cnt_d);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({rst_d, ready_d, lost_d, cnt_d, cnt_l, rst_m} !== {2'b11, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got rst=%b rdy=%b lost=%b cnt=%0d lc_cnt=%0d min_rst=%b want 11 0 0 0 0 1",
               rst_d, ready_d, lost_d, cnt_d, cnt_l, rst_m);
    end
    tick();
    reset = 1'b0;
    detected = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_release();
    test_run_drops();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
